// File: rtl/ft_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ft_bus_arbiter
//
// Sequencer for the FT600 245-synchronous FIFO bus. One half-duplex data bus
// is shared between a host->FPGA read stream (rx_*) and an FPGA->host write
// stream (tx_*). Bursts are bounded to MAX_BURST words. When both directions
// are eligible, grants alternate. Every direction change passes through an
// END state and then IDLE, so the FPGA pin drivers and the FT600 output
// enable are never active together.
//
// Ports
//   ft_clk, rst         : FT600 clock (only clock); synchronous active-high reset
//   ft_rxf_n, ft_txe_n  : FT600 status (low = read data available / write space)
//   ft_data_in, ft_be_in: bus read data / byte enables
//   ft_data_out,
//   ft_be_out           : write holding register, driven onto the bus
//   ft_data_oe          : 1 = FPGA drives the data/BE pins
//   ft_oe_n, ft_rd_n,
//   ft_wr_n             : FT600 strobes (active low, registered)
//   rx_data, rx_be,
//   rx_valid            : received word, one-cycle valid, no backpressure
//   rx_afull            : downstream almost full (absorbs 2 more words)
//   tx_data, tx_be,
//   tx_valid, tx_ready  : write stream, transfer on tx_valid && tx_ready
//   busy                : sequencer is not idle
// ---------------------------------------------------------------------------
module ft_bus_arbiter #(
    parameter int DATA_W    = 16,
    parameter int BE_W      = 2,
    parameter int MAX_BURST = 256,
    parameter int CNT_W     = 16
) (
    input  logic              ft_clk,
    input  logic              rst,
    input  logic              ft_rxf_n,
    input  logic              ft_txe_n,
    input  logic [DATA_W-1:0] ft_data_in,
    input  logic [BE_W-1:0]   ft_be_in,
    output logic [DATA_W-1:0] ft_data_out,
    output logic [BE_W-1:0]   ft_be_out,
    output logic              ft_data_oe,
    output logic              ft_oe_n,
    output logic              ft_rd_n,
    output logic              ft_wr_n,
    output logic [DATA_W-1:0] rx_data,
    output logic [BE_W-1:0]   rx_be,
    output logic              rx_valid,
    input  logic              rx_afull,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [BE_W-1:0]   tx_be,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_OE,
        S_RD,
        S_RD_END,
        S_WR,
        S_WR_END
    } state_t;

    // Index of the final word in a burst.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BURST - 1);

    state_t           state_reg;
    state_t           state_next;
    logic             pend_reg;        // holding register has an unaccepted word
    logic [CNT_W-1:0] burst_cnt_reg;   // words moved in the current grant
    logic             last_grant_reg;  // 1 = last grant was write

    logic capture;
    logic accept;
    logic rd_elig;
    logic wr_elig;
    logic grant_rd;
    logic grant_wr;
    logic burst_has_room;
    logic tx_fire;

    // The strobes are registered outputs. These conditions use the strobe
    // values the FT600 sees during this cycle.
    assign capture  = !ft_rd_n && !ft_rxf_n;
    assign accept   = !ft_wr_n && !ft_txe_n;

    assign rd_elig  = !ft_rxf_n && !rx_afull;
    assign wr_elig  = !ft_txe_n && (tx_valid || pend_reg);

    // When both directions are eligible, the direction not granted last time wins.
    assign grant_rd = (state_reg == S_IDLE) && rd_elig && (!wr_elig || last_grant_reg);
    assign grant_wr = (state_reg == S_IDLE) && wr_elig && !grant_rd;

    // Allows one more reload after the word accepted at this edge.
    assign burst_has_room = (burst_cnt_reg < LAST_IDX);

    // Pops are gated by rst. A word popped during reset would otherwise be
    // lost when the holding register clears.
    assign tx_ready = !rst &&
                      ((grant_wr && !pend_reg && tx_valid) ||
                       ((state_reg == S_WR) && accept && tx_valid && burst_has_room));
    assign tx_fire  = tx_valid && tx_ready;

    assign busy     = (state_reg != S_IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_rd) begin
                    state_next = S_RD_OE;
                end else if (grant_wr) begin
                    state_next = S_WR;
                end
            end
            S_RD_OE:  state_next = S_RD;
            S_RD: begin
                if (ft_rxf_n || rx_afull || (capture && (burst_cnt_reg == LAST_IDX))) begin
                    state_next = S_RD_END;
                end
            end
            S_RD_END: state_next = S_IDLE;
            S_WR: begin
                // If ft_txe_n is high, the unaccepted word stays pending for the next grant.
                if (ft_txe_n || (accept && !tx_fire)) begin
                    state_next = S_WR_END;
                end
            end
            S_WR_END: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ft_clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ft_oe_n        <= 1'b1;
            ft_rd_n        <= 1'b1;
            ft_wr_n        <= 1'b1;
            ft_data_oe     <= 1'b0;
            ft_data_out    <= '0;
            ft_be_out      <= '0;
            rx_data        <= '0;
            rx_be          <= '0;
            rx_valid       <= 1'b0;
            pend_reg       <= 1'b0;
            burst_cnt_reg  <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;

            // Strobes follow the next state so they change at the same edge as the state.
            ft_oe_n    <= !((state_next == S_RD_OE) || (state_next == S_RD));
            ft_rd_n    <= !(state_next == S_RD);
            ft_wr_n    <= !(state_next == S_WR);
            ft_data_oe <= (state_next == S_WR);

            rx_valid   <= capture;
            if (capture) begin
                rx_data <= ft_data_in;
                rx_be   <= ft_be_in;
            end

            // A grant happens only in IDLE, where no capture or accept can occur.
            if (grant_rd || grant_wr) begin
                burst_cnt_reg  <= '0;
                last_grant_reg <= grant_wr;
            end else if (capture || accept) begin
                burst_cnt_reg  <= burst_cnt_reg + 1'b1;
            end

            if (tx_fire) begin
                ft_data_out <= tx_data;
                ft_be_out   <= tx_be;
                pend_reg    <= 1'b1;
            end else if (accept) begin
                pend_reg    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ft_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ft_bus_arbiter
//
// Directed bench for ft_bus_arbiter with MAX_BURST = 4. The bench drives
// inputs on the falling edge and samples outputs on the falling edge (or
// 1 time unit later, where combinational tx_ready is needed). It plays the
// FT600 and the packet logic around the arbiter.
// ---------------------------------------------------------------------------
module tb_ft_bus_arbiter;

    localparam int MAXB = 4;

    logic        ft_clk = 1'b0;
    logic        rst;
    logic        ft_rxf_n;
    logic        ft_txe_n;
    logic [15:0] ft_data_in;
    logic [1:0]  ft_be_in;
    logic [15:0] ft_data_out;
    logic [1:0]  ft_be_out;
    logic        ft_data_oe;
    logic        ft_oe_n;
    logic        ft_rd_n;
    logic        ft_wr_n;
    logic [15:0] rx_data;
    logic [1:0]  rx_be;
    logic        rx_valid;
    logic        rx_afull;
    logic [15:0] tx_data;
    logic [1:0]  tx_be;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ft_bus_arbiter #(
        .DATA_W(16), .BE_W(2), .MAX_BURST(MAXB), .CNT_W(16)
    ) dut (
        .ft_clk(ft_clk), .rst(rst),
        .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n),
        .ft_data_in(ft_data_in), .ft_be_in(ft_be_in),
        .ft_data_out(ft_data_out), .ft_be_out(ft_be_out), .ft_data_oe(ft_data_oe),
        .ft_oe_n(ft_oe_n), .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n),
        .rx_data(rx_data), .rx_be(rx_be), .rx_valid(rx_valid), .rx_afull(rx_afull),
        .tx_data(tx_data), .tx_be(tx_be), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 ft_clk = ~ft_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        ft_rxf_n   = 1'b1;
        ft_txe_n   = 1'b1;
        ft_data_in = 16'h0000;
        ft_be_in   = 2'b00;
        rx_afull   = 1'b0;
        tx_data    = 16'h0000;
        tx_be      = 2'b00;
        tx_valid   = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge ft_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge ft_clk);
        n_checks++;
        if ({ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe, busy, rx_valid, tx_ready} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 1110000",
                     {ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe, busy, rx_valid, tx_ready});
        end
        n_checks++;
        if ({ft_data_out, ft_be_out, rx_data, rx_be} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {ft_data_out, ft_be_out, rx_data, rx_be});
        end
        rst = 1'b0;
        repeat (3) @(negedge ft_clk);
        n_checks++;
        if ({busy, ft_oe_n, ft_wr_n} !== 3'b011) begin
            n_fail++;
            $display("FAIL reset_idle: busy/oe_n/wr_n got %b want 011", {busy, ft_oe_n, ft_wr_n});
        end
        $display("test_reset done");
    endtask

    // Ten host words, delivered as bursts of 4 + 4 + 2.
    task automatic test_read_burst();
        int idx = 0, rcv = 0, grants = 0, oe_fall = -10, lead_bad = 0, rise_bad = 0;
        logic prev_oe_n = 1'b1, prev_rd_n = 1'b1;
        do_reset();
        for (int cyc = 0; cyc < 80 && !(idx == 10 && rcv == 10 && !busy); cyc++) begin
            @(negedge ft_clk);
            if (rx_valid) begin
                n_checks++;
                if ({rx_data, rx_be} !== {16'(rcv + 1), 2'b11}) begin
                    n_fail++;
                    $display("FAIL rd_word%0d: got %h/%b want %h/11", rcv, rx_data, rx_be, 16'(rcv + 1));
                end
                rcv++;
            end
            if (prev_oe_n && !ft_oe_n) begin
                oe_fall = cyc;
                grants++;
            end
            if (prev_rd_n && !ft_rd_n && (cyc - oe_fall != 1)) lead_bad++;
            if (!prev_rd_n && ft_rd_n && !ft_oe_n) rise_bad++;
            prev_oe_n = ft_oe_n;
            prev_rd_n = ft_rd_n;
            ft_rxf_n   = (idx >= 10);
            ft_data_in = 16'(idx + 1);
            ft_be_in   = 2'b11;
            if (!ft_rd_n && !ft_rxf_n) idx++;
        end
        n_checks++;
        if (rcv != 10) begin
            n_fail++;
            $display("FAIL rd_count: got %0d want 10", rcv);
        end
        n_checks++;
        if (grants != 3) begin
            n_fail++;
            $display("FAIL rd_grants: got %0d want 3", grants);
        end
        n_checks++;
        if (lead_bad != 0 || rise_bad != 0) begin
            n_fail++;
            $display("FAIL rd_oe_lead: lead errors %0d end errors %0d want 0", lead_bad, rise_bad);
        end
        n_checks++;
        if ({busy, ft_oe_n, ft_rd_n} !== 3'b011) begin
            n_fail++;
            $display("FAIL rd_exit: busy/oe_n/rd_n got %b want 011", {busy, ft_oe_n, ft_rd_n});
        end
        $display("test_read_burst done: %0d words in %0d grants", rcv, grants);
    endtask

    // Five words, sent as bursts of 4 + 1.
    task automatic test_write_burst();
        int idx = 0, acc = 0, wr_low = 0, oe_high = 0, oe_mis = 0, run = 0, max_run = 0;
        do_reset();
        for (int cyc = 0; cyc < 60 && !(acc == 5 && !busy); cyc++) begin
            @(negedge ft_clk);
            ft_txe_n = 1'b0;
            tx_valid = (idx < 5);
            tx_data  = 16'hA000 + 16'(idx);
            tx_be    = 2'b11;
            #1;
            if (!ft_wr_n) begin
                wr_low++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (ft_data_oe) oe_high++;
            if (ft_data_oe !== !ft_wr_n) oe_mis++;
            if (!ft_wr_n && !ft_txe_n) begin
                n_checks++;
                if ({ft_data_out, ft_be_out} !== {16'hA000 + 16'(acc), 2'b11}) begin
                    n_fail++;
                    $display("FAIL wr_word%0d: got %h/%b want %h/11", acc, ft_data_out, ft_be_out,
                             16'hA000 + 16'(acc));
                end
                acc++;
            end
            if (tx_valid && tx_ready) idx++;
        end
        tx_valid = 1'b0;
        n_checks++;
        if (acc != 5 || idx != 5) begin
            n_fail++;
            $display("FAIL wr_count: accepted %0d popped %0d want 5/5", acc, idx);
        end
        n_checks++;
        if (wr_low != 5 || oe_high != 5 || oe_mis != 0) begin
            n_fail++;
            $display("FAIL wr_strobes: wr_n low %0d oe high %0d mismatch %0d want 5/5/0",
                     wr_low, oe_high, oe_mis);
        end
        n_checks++;
        if (max_run != MAXB) begin
            n_fail++;
            $display("FAIL wr_burst_len: got %0d want %0d", max_run, MAXB);
        end
        $display("test_write_burst done: %0d words", acc);
    endtask

    task automatic test_contention();
        int rdi = 0, txi = 0, rcv = 0, acc = 0, nb = 0, overlap = 0;
        int btype [8];
        int bwords [8];
        logic prev_oe_n = 1'b1, prev_wr_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            btype[i]  = -1;
            bwords[i] = 0;
        end
        do_reset();
        for (int cyc = 0; cyc < 80 && nb < 5; cyc++) begin
            @(negedge ft_clk);
            ft_rxf_n   = 1'b0;
            ft_data_in = 16'h5000 + 16'(rdi);
            ft_be_in   = 2'b01;
            ft_txe_n   = 1'b0;
            tx_valid   = 1'b1;
            tx_data    = 16'hC000 + 16'(txi);
            tx_be      = 2'b10;
            #1;
            if (prev_oe_n && !ft_oe_n) begin
                if (nb < 8) btype[nb] = 0;
                nb++;
            end
            if (prev_wr_n && !ft_wr_n) begin
                if (nb < 8) btype[nb] = 1;
                nb++;
            end
            prev_oe_n = ft_oe_n;
            prev_wr_n = ft_wr_n;
            if (ft_data_oe && !ft_oe_n) overlap++;
            if (rx_valid) begin
                n_checks++;
                if ({rx_data, rx_be} !== {16'h5000 + 16'(rcv), 2'b01}) begin
                    n_fail++;
                    $display("FAIL ct_rd%0d: got %h/%b want %h/01", rcv, rx_data, rx_be, 16'h5000 + 16'(rcv));
                end
                rcv++;
            end
            if (!ft_rd_n && !ft_rxf_n) begin
                rdi++;
                if (nb > 0 && nb <= 8) bwords[nb-1]++;
            end
            if (!ft_wr_n && !ft_txe_n) begin
                n_checks++;
                if ({ft_data_out, ft_be_out} !== {16'hC000 + 16'(acc), 2'b10}) begin
                    n_fail++;
                    $display("FAIL ct_wr%0d: got %h/%b want %h/10", acc, ft_data_out, ft_be_out,
                             16'hC000 + 16'(acc));
                end
                acc++;
                if (nb > 0 && nb <= 8) bwords[nb-1]++;
            end
            if (tx_valid && tx_ready) txi++;
        end
        drive_idle();
        repeat (4) @(negedge ft_clk);
        n_checks++;
        if (!(btype[0] == 0 && btype[1] == 1 && btype[2] == 0 && btype[3] == 1)) begin
            n_fail++;
            $display("FAIL ct_order: got %0d %0d %0d %0d want 0 1 0 1 (0=RD 1=WR)",
                     btype[0], btype[1], btype[2], btype[3]);
        end
        n_checks++;
        if (!(bwords[0] == MAXB && bwords[1] == MAXB && bwords[2] == MAXB && bwords[3] == MAXB)) begin
            n_fail++;
            $display("FAIL ct_len: got %0d %0d %0d %0d want %0d each",
                     bwords[0], bwords[1], bwords[2], bwords[3], MAXB);
        end
        n_checks++;
        if (overlap != 0 || txi != acc || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ct_misc: overlap %0d popped %0d accepted %0d busy %b want 0/equal/0",
                     overlap, txi, acc, busy);
        end
        $display("test_contention done: %0d bursts seen, %0d rd %0d wr words", nb, rcv, acc);
    endtask

    task automatic test_tx_stall();
        int pops = 0, acc = 0, ready_bad = 0;
        logic [15:0] words [4];
        for (int i = 0; i < 4; i++) words[i] = 16'h0;
        do_reset();
        @(negedge ft_clk);
        ft_txe_n = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 16'hBEEF;
        tx_be    = 2'b11;
        #1;
        n_checks++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL st_pop: tx_ready got %b want 1", tx_ready);
        end
        pops = 1;
        @(negedge ft_clk);
        n_checks++;
        if ({ft_wr_n, ft_data_out} !== {1'b0, 16'hBEEF}) begin
            n_fail++;
            $display("FAIL st_bus: wr_n/data got %b/%h want 0/beef", ft_wr_n, ft_data_out);
        end
        ft_txe_n = 1'b1;
        tx_data  = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (tx_ready !== 1'b0) ready_bad++;
            @(negedge ft_clk);
        end
        n_checks++;
        if (ready_bad != 0 || {busy, ft_wr_n, ft_data_oe} !== 3'b010) begin
            n_fail++;
            $display("FAIL st_hold: ready pulses %0d busy/wr_n/oe %b want 0 and 010",
                     ready_bad, {busy, ft_wr_n, ft_data_oe});
        end
        ft_txe_n = 1'b0;
        #1;
        n_checks++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL st_pend: tx_ready got %b want 0 while word pending", tx_ready);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (!ft_wr_n && !ft_txe_n) begin
                if (acc < 4) words[acc] = ft_data_out;
                acc++;
            end
            if (tx_valid && tx_ready) pops++;
            @(negedge ft_clk);
            tx_valid = (pops < 2);
            #1;
        end
        n_checks++;
        if (acc != 2 || pops != 2 || words[0] !== 16'hBEEF || words[1] !== 16'h1234) begin
            n_fail++;
            $display("FAIL st_resend: bus %0d words (%h %h) popped %0d want 2 (beef 1234) popped 2",
                     acc, words[0], words[1], pops);
        end
        drive_idle();
        $display("test_tx_stall done: %0d words on bus", acc);
    endtask

    task automatic test_backpressure();
        int rdi = 0, rcv = 0, after_cnt = 0, hold = 0, grant_bad = 0;
        logic afull_set = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 60 && hold < 10; cyc++) begin
            @(negedge ft_clk);
            if (rx_valid) begin
                n_checks++;
                if (rx_data !== 16'h6000 + 16'(rcv)) begin
                    n_fail++;
                    $display("FAIL bp_word%0d: got %h want %h", rcv, rx_data, 16'h6000 + 16'(rcv));
                end
                rcv++;
                if (afull_set) after_cnt++;
            end
            if (afull_set) begin
                hold++;
                if (hold == 1) begin
                    n_checks++;
                    if (ft_rd_n !== 1'b1) begin
                        n_fail++;
                        $display("FAIL bp_rd_stop: ft_rd_n got %b want 1", ft_rd_n);
                    end
                end
                if (!ft_oe_n) grant_bad++;
            end
            ft_rxf_n   = 1'b0;
            ft_data_in = 16'h6000 + 16'(rdi);
            ft_be_in   = 2'b11;
            if (!afull_set && rcv == 2) afull_set = 1'b1;
            rx_afull = afull_set;
            if (!ft_rd_n && !ft_rxf_n) rdi++;
        end
        n_checks++;
        if (after_cnt != 1 || rcv != 3) begin
            n_fail++;
            $display("FAIL bp_after: words after afull %0d total %0d want 1/3", after_cnt, rcv);
        end
        n_checks++;
        if (grant_bad != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_grant: oe_n low cycles %0d busy %b want 0/0", grant_bad, busy);
        end
        drive_idle();
        $display("test_backpressure done: %0d words", rcv);
    endtask

    task automatic test_reset_mid_write();
        int wr_seen = 0, wr_after = 0;
        do_reset();
        for (int cyc = 0; cyc < 10 && wr_seen == 0; cyc++) begin
            @(negedge ft_clk);
            ft_txe_n = 1'b0;
            tx_valid = 1'b1;
            tx_data  = 16'h7000 + 16'(cyc);
            tx_be    = 2'b11;
            #1;
            if (!ft_wr_n) wr_seen = 1;
        end
        n_checks++;
        if (wr_seen != 1) begin
            n_fail++;
            $display("FAIL rw_start: write burst not started, got %0d want 1", wr_seen);
        end
        rst      = 1'b1;
        tx_valid = 1'b0;
        @(negedge ft_clk);
        n_checks++;
        if ({ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe, busy} !== 5'b11100 ||
            {ft_data_out, ft_be_out} !== 18'h0) begin
            n_fail++;
            $display("FAIL rw_reset: strobes/oe/busy %b data %h want 11100 and 0",
                     {ft_oe_n, ft_rd_n, ft_wr_n, ft_data_oe, busy}, {ft_data_out, ft_be_out});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ft_clk);
            if (!ft_wr_n || busy) wr_after++;
        end
        n_checks++;
        if (wr_after != 0) begin
            n_fail++;
            $display("FAIL rw_pend_cleared: busy/write cycles %0d want 0", wr_after);
        end
        drive_idle();
        $display("test_reset_mid_write done");
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        test_reset();
        test_read_burst();
        test_write_burst();
        test_contention();
        test_tx_stall();
        test_backpressure();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
